// File: rtl/msrv32_pkg.sv
// ============================================================================
// msrv32_pkg : shared encodings for the MEM-stage load align unit
// Rev 1.0
// ============================================================================
`default_nettype none

package msrv32_pkg;

  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;
  localparam logic [1:0] LS_D = 2'b11;

  localparam logic [1:0] LU_OK     = 2'b00;
  localparam logic [1:0] LU_BUSERR = 2'b01;
  localparam logic [1:0] LU_MISAL  = 2'b10;
  localparam logic [1:0] LU_BADSZ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } lu_state_e;

endpackage

`default_nettype wire

// File: rtl/msrv32_lu_extract.sv
// ============================================================================
// msrv32_lu_extract : selects the addressed bytes from two beats and extends
// Rev 1.0
// ============================================================================
`default_nettype none

module msrv32_lu_extract
  import msrv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [XLEN-1:0]   o_result
);

  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;

  always_comb begin
    w_sh   = XLEN'(i_data >> {i_off, 3'b000});
    w_mask = '1;
    w_sign = w_sh[XLEN-1];
    case (i_size)
      LS_B: begin w_mask = XLEN'(8'hFF);         w_sign = w_sh[7];  end
      LS_H: begin w_mask = XLEN'(16'hFFFF);      w_sign = w_sh[15]; end
      LS_W: begin w_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_sh[31]; end
      default: ;
    endcase
    // Bits above the access width come from the sign bit unless zero-extending.
    o_result = (w_sh & w_mask) | ((w_sign && !i_unsigned) ? ~w_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/msrv32_load_align_unit.sv
// ============================================================================
// msrv32_load_align_unit : one- or two-beat aligned load unit for the AHB port
// Rev 1.0
// ============================================================================
`default_nettype none

module msrv32_load_align_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              ld_valid_in,
  output logic              ld_ready_out,
  input  logic [ADDR_W-1:0] ld_addr_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic              ld_flush_in,
  output logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
  output logic              dm_rd_req_out,
  input  logic              ahb_ready_in,
  input  logic              ahb_resp_in,
  input  logic [XLEN-1:0]   ms_riscv32_mp_dmdata_in,
  output logic [XLEN-1:0]   lu_output_out,
  output logic              lu_valid_out,
  output logic [1:0]        lu_err_out
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lu_state_e         r_state, w_state;
  logic [ADDR_W-1:0] r_base;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_split;
  logic              r_kill;
  logic [1:0]        r_err;
  logic [XLEN-1:0]   r_lo, r_hi;

  logic [OFF_W-1:0]  w_off;
  logic [4:0]        w_span;
  logic              w_split, w_illegal, w_accept;
  logic [XLEN-1:0]   w_ext;

  assign w_off     = ld_addr_in[OFF_W-1:0];
  assign w_span    = 5'(w_off) + (5'd1 << load_size_in);
  assign w_split   = (w_span > 5'(NB));
  assign w_illegal = (load_size_in == LS_D) && (XLEN == 32);
  assign w_accept  = ld_valid_in && (r_state == IDLE);

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) r_state <= IDLE;
    else                       r_state <= w_state;
  end

  always_comb begin
    w_state                  = r_state;
    ld_ready_out             = 1'b0;
    dm_rd_req_out            = 1'b0;
    ms_riscv32_mp_dmaddr_out = '0;
    case (r_state)
      IDLE: begin
        ld_ready_out = 1'b1;
        if (ld_valid_in) begin
          if (w_illegal || (w_split && (MISALIGN_EN == 0))) w_state = RESP;
          else                                              w_state = BEAT0;
        end
      end
      BEAT0: begin
        dm_rd_req_out            = 1'b1;
        ms_riscv32_mp_dmaddr_out = r_base;
        if (ahb_ready_in) w_state = (r_split && !ahb_resp_in) ? BEAT1 : RESP;
      end
      BEAT1: begin
        dm_rd_req_out            = 1'b1;
        ms_riscv32_mp_dmaddr_out = r_base + ADDR_W'(NB);
        if (ahb_ready_in) w_state = RESP;
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  msrv32_lu_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extract (
    .i_data     ({r_hi, r_lo}),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_result   (w_ext)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_base        <= '0;
      r_off         <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
      r_split       <= 1'b0;
      r_kill        <= 1'b0;
      r_err         <= LU_OK;
      r_lo          <= '0;
      r_hi          <= '0;
      lu_output_out <= '0;
      lu_valid_out  <= 1'b0;
      lu_err_out    <= LU_OK;
    end else begin
      lu_valid_out <= 1'b0;
      if (w_accept) begin
        r_base  <= {ld_addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        r_off   <= w_off;
        r_size  <= load_size_in;
        r_uns   <= load_unsigned_in;
        r_split <= w_split;
        r_kill  <= ld_flush_in;
        if (w_illegal)                                r_err <= LU_BADSZ;
        else if (w_split && (MISALIGN_EN == 0))       r_err <= LU_MISAL;
        else                                          r_err <= LU_OK;
      end else if (r_state != IDLE && ld_flush_in) begin
        r_kill <= 1'b1;
      end
      if (r_state == BEAT0 && ahb_ready_in) begin
        r_lo <= ms_riscv32_mp_dmdata_in;
        if (ahb_resp_in) r_err <= LU_BUSERR;
      end
      if (r_state == BEAT1 && ahb_ready_in) begin
        r_hi <= ms_riscv32_mp_dmdata_in;
        if (ahb_resp_in) r_err <= LU_BUSERR;
      end
      // A killed load leaves the previous result and error code visible.
      if (r_state == RESP && !r_kill) begin
        lu_valid_out  <= 1'b1;
        lu_err_out    <= r_err;
        lu_output_out <= (r_err == LU_OK) ? w_ext : '0;
      end
    end
  end

endmodule

`default_nettype wire
